// File: rtl/bbc_timing_pkg.sv
// -----------------------------------------------------------------------------
// bbc_timing_pkg
//
// Shared timing definitions for the 2 MHz / 1 MHz clock-enable generator.
//
// Contents:
//   stretch_state_e     - CPU-cycle stretcher states (IDLE, SYNC, ACCESS)
//   SLOT_A / SLOT_B     - encoding of the 1 MHz half-period flag (ph1m)
//   DEFAULT_CLK_PER_2M  - system clocks per 2 MHz slot at 32 MHz
//   div_width()         - counter width needed for a given slot length
// -----------------------------------------------------------------------------
package bbc_timing_pkg;

  // IDLE   : normal 2 MHz CPU cycles.
  // SYNC   : request arrived in slot B; waiting out that slot so the
  //          access can start aligned to a 1 MHz period.
  // ACCESS : the CPU cycle is held for the slot B that completes the
  //          1 MHz period.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACCESS = 2'd2
  } stretch_state_e;

  // ph1m value during each half of a 1 MHz period.
  localparam logic SLOT_A = 1'b0;
  localparam logic SLOT_B = 1'b1;

  // 32 MHz system clock / 2 MHz slot rate.
  localparam int DEFAULT_CLK_PER_2M = 16;

  // Width of a counter that must hold 0..clk_per_slot-1.
  function automatic int div_width(input int clk_per_slot);
    return (clk_per_slot <= 2) ? 1 : $clog2(clk_per_slot);
  endfunction

endpackage : bbc_timing_pkg

// File: rtl/mhz1_cycle_stretcher_slot_timebase.sv
// -----------------------------------------------------------------------------
// slot_timebase
//
// Free-running 2 MHz slot counter and 1 MHz phase flag. The timebase never
// stalls; the stretcher only decides which slot ends become CPU cycle ends.
//
// Parameters:
//   CLK_PER_2M  system clocks per 2 MHz slot (even, >= 4)
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset (div_cnt=0, ph1m=SLOT_A)
//   decision_pt  out  high in the cycle whose closing edge is the decision
//                     point (div_cnt == CLK_PER_2M-2)
//   slot_end     out  high in the last cycle of a slot (div_cnt == CLK_PER_2M-1)
//   slot_b       out  current slot is slot B (ph1m, a flop output)
// -----------------------------------------------------------------------------
module slot_timebase
  import bbc_timing_pkg::*;
#(
  parameter int CLK_PER_2M = DEFAULT_CLK_PER_2M
) (
  input  logic clk,
  input  logic reset,
  output logic decision_pt,
  output logic slot_end,
  output logic slot_b
);

  localparam int CW = div_width(CLK_PER_2M);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_PER_2M - 1);
  localparam logic [CW-1:0] DIV_DECIDE = CW'(CLK_PER_2M - 2);

  logic [CW-1:0] div_cnt_reg;
  logic          ph1m_reg;

  // ph1m flips exactly when the counter wraps, so a 1 MHz period is always
  // one slot A followed by one slot B.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
      ph1m_reg    <= SLOT_A;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
      ph1m_reg    <= ~ph1m_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign decision_pt = (div_cnt_reg == DIV_DECIDE);
  assign slot_end    = (div_cnt_reg == DIV_LAST);
  assign slot_b      = (ph1m_reg == SLOT_B);

endmodule : slot_timebase

// File: rtl/mhz1_cycle_stretcher.sv
// -----------------------------------------------------------------------------
// mhz1_cycle_stretcher
//
// Produces the 2 MHz CPU clock enable and the 1 MHz peripheral clock enable.
// A CPU cycle flagged by the address decoder as a 1 MHz access is stretched
// so the access covers one whole 1 MHz period (slot A + slot B):
//   request decided in slot A -> cycle lasts 2 slots
//   request decided in slot B -> cycle lasts 3 slots (waits for next slot A)
//
// Parameters:
//   CLK_PER_2M  system clocks per 2 MHz slot (even, >= 4)
//
// Ports:
//   clk         in   system clock (32 MHz nominal)
//   reset       in   synchronous active-high reset; aborts any stretch
//   mhz1_req    in   address decoder's 1 MHz region flag for this CPU cycle
//   stretch_en  in   0 = ignore mhz1_req, never stretch
//   cpu_clken   out  one-clk pulse ending each CPU cycle
//   mhz1_clken  out  one-clk pulse at the end of every 1 MHz period
//   mhz1_phase  out  0 in slot A, 1 in slot B
//   stretching  out  high while the CPU cycle is being held
//   io_commit   out  one-clk pulse with cpu_clken ending a stretched access
//
// All outputs are flops. Pulses are computed at the decision-point edge so
// they are high exactly during the slot-end cycle that follows it.
// -----------------------------------------------------------------------------
module mhz1_cycle_stretcher
  import bbc_timing_pkg::*;
#(
  parameter int CLK_PER_2M = DEFAULT_CLK_PER_2M
) (
  input  logic clk,
  input  logic reset,
  input  logic mhz1_req,
  input  logic stretch_en,
  output logic cpu_clken,
  output logic mhz1_clken,
  output logic mhz1_phase,
  output logic stretching,
  output logic io_commit
);

  logic decision_pt;
  logic slot_end;
  logic slot_b;

  slot_timebase #(
    .CLK_PER_2M (CLK_PER_2M)
  ) u_timebase (
    .clk         (clk),
    .reset       (reset),
    .decision_pt (decision_pt),
    .slot_end    (slot_end),
    .slot_b      (slot_b)
  );

  stretch_state_e state_reg;
  logic           cpu_clken_reg;
  logic           mhz1_clken_reg;
  logic           stretching_reg;
  logic           io_commit_reg;

  logic req;
  assign req = mhz1_req & stretch_en;

  // Single FSM + output register block. Inputs are only looked at on the
  // decision-point edge while IDLE; once a stretch starts it runs to
  // completion regardless of mhz1_req / stretch_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cpu_clken_reg  <= 1'b0;
      mhz1_clken_reg <= 1'b0;
      stretching_reg <= 1'b0;
      io_commit_reg  <= 1'b0;
    end else begin
      // Pulses default low so they last exactly the slot-end cycle.
      cpu_clken_reg  <= 1'b0;
      mhz1_clken_reg <= 1'b0;
      io_commit_reg  <= 1'b0;

      if (decision_pt) begin
        // The slot about to end is slot B: that closes a 1 MHz period.
        mhz1_clken_reg <= slot_b;

        case (state_reg)
          IDLE: begin
            if (req) begin
              // Starting in slot B needs one extra slot to realign with
              // the start of a 1 MHz period.
              state_reg      <= slot_b ? SYNC : ACCESS;
              stretching_reg <= 1'b1;
            end else begin
              cpu_clken_reg  <= 1'b1;
            end
          end
          SYNC: begin
            state_reg <= ACCESS;
          end
          ACCESS: begin
            state_reg     <= IDLE;
            cpu_clken_reg <= 1'b1;
            io_commit_reg <= 1'b1;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end else if (slot_end) begin
        // stretching stays high through the commit slot end and drops on
        // the first cycle of the next CPU cycle.
        stretching_reg <= (state_reg != IDLE);
      end
    end
  end

  assign cpu_clken  = cpu_clken_reg;
  assign mhz1_clken = mhz1_clken_reg;
  assign mhz1_phase = slot_b;
  assign stretching = stretching_reg;
  assign io_commit  = io_commit_reg;

endmodule : mhz1_cycle_stretcher

// File: doc/mhz1_cycle_stretcher.md
Name: mhz1_cycle_stretcher

Overview:
- Generates the 2 MHz CPU clock enable and the 1 MHz peripheral clock enable from the system clock.
- Stretches any CPU cycle flagged by the address decoder's 1 MHz bus request, so that the access spans one complete 1 MHz period, as on the original machine.
- Sits between the address decoder (mhz1_enable output) and the 6502 core, VIAs, ACIA, serial ULA, CRTC and ADC clock-enable inputs.

Parameters:
- CLK_PER_2M, 16, system clocks per 2 MHz slot; must be even and at least 4.

Ports:
- clk  in  1  system clock (32 MHz nominal); single clock domain.
- reset  in  1  synchronous, active-high reset.
- mhz1_req  in  1  address decoder's 1 MHz region flag for the current CPU cycle.
- stretch_en  in  1  when 0, mhz1_req is ignored and no cycle is ever stretched.
- cpu_clken  out  1  one-clk pulse that ends each CPU cycle; registered.
- mhz1_clken  out  1  one-clk pulse at the end of every 1 MHz period; registered.
- mhz1_phase  out  1  0 during slot A, 1 during slot B of the current 1 MHz period; registered.
- stretching  out  1  high while the CPU cycle is being held (state SYNC or ACCESS); registered.
- io_commit  out  1  one-clk pulse, coincident with cpu_clken, that ends a stretched 1 MHz access; registered.

Behaviour:
- Timebase:
  - div_cnt counts 0..CLK_PER_2M-1 and wraps.
  - ph1m toggles on each wrap. ph1m=0 is slot A; ph1m=1 is slot B.
  - A 1 MHz period is slot A followed by slot B.
- Reset:
  - div_cnt=0, ph1m=0, state=IDLE.
  - All outputs are 0 in the cycle after reset is sampled.
  - The first slot after reset release is slot A, starting at div_cnt=0.
- Slot end: the cycle in which div_cnt==CLK_PER_2M-1. All output pulses occur only in slot-end cycles.
- Decision point: the clock edge at which div_cnt==CLK_PER_2M-2.
  - mhz1_req and stretch_en are sampled only here, and only when state==IDLE.
  - Changes to mhz1_req at any other time have no effect.
- Let req = mhz1_req & stretch_en.
- State machine, transitions taken at the decision point:
  - IDLE, req=0: stay in IDLE; cpu_clken fires at this slot end.
  - IDLE, req=1, current slot A: go to ACCESS; cpu_clken is suppressed at this slot end.
  - IDLE, req=1, current slot B: go to SYNC; cpu_clken is suppressed.
  - SYNC, always in slot A: go to ACCESS; cpu_clken is suppressed.
  - ACCESS, always in slot B: go to IDLE; cpu_clken and io_commit both fire at this slot end.
- Resulting CPU cycle length:
  - A 1 MHz access starting in slot A lasts 2 slots.
  - A 1 MHz access starting in slot B lasts 3 slots.
  - A normal cycle lasts 1 slot.
- Other outputs:
  - mhz1_clken fires at every slot B end, independent of state.
  - stretching is high from the slot end following a req=1 decision through the slot end at which io_commit fires, inclusive.
  - mhz1_phase equals ph1m.
- Back-to-back 1 MHz accesses: the next CPU cycle begins in slot A, so it takes 2 slots. There is no dead cycle.
- stretch_en falling while in SYNC or ACCESS: the stretch in progress completes; the new value applies at the next IDLE decision.
- Reset asserted mid-stretch: abort immediately to IDLE with the timebase zeroed. No io_commit is emitted.
- Invariant: the timebase never stalls. cpu_clken and mhz1_clken never fire outside slot-end cycles.

Decomposition:
- Shared package bbc_timing_pkg holds:
  - the state enum (IDLE, SYNC, ACCESS);
  - the constant SLOT_A=0 / SLOT_B=1;
  - the default CLK_PER_2M.
- One sub-module: slot_timebase. It owns div_cnt and ph1m and outputs decision_pt, slot_end and slot_b.
- The FSM and output registers stay in mhz1_cycle_stretcher.

Test Plan (CLK_PER_2M=16, cycle 0 = first cycle after reset release):
- Idle, mhz1_req=0 -> cpu_clken at cycles 15, 31, 47, 63; mhz1_clken at 31, 63; mhz1_phase=1 during 16-31; stretching stays 0.
- mhz1_req=1 held during cycles 0-15, stretch_en=1 -> cpu_clken absent at 15; cpu_clken and io_commit at 31; stretching high in cycles 15-31.
- mhz1_req=1 during cycles 16-31 only -> cpu_clken absent at 31 and 47; cpu_clken and io_commit at 63; stretching high in cycles 31-63.
- mhz1_req=1 continuously from cycle 0 -> cpu_clken/io_commit at 31, 63, 95; no pulses at 15, 47, 79.
- stretch_en=0 with mhz1_req=1 -> identical to the idle case; io_commit never fires.
- Request in slot B, reset pulsed at cycle 40 (mid-stretch) -> all outputs 0 at cycle 41; after release, the next cpu_clken arrives 16 cycles after the release edge; no io_commit.
